// File: rtl/jstk2_spi_responder_if.sv
// SPI bus between a joystick SPI master and the JSTK2 responder (mode 0).
interface jstk2_spi_responder_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS, output MOSI, input MISO);
  modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/jstk2_spi_responder.sv
// Pmod JSTK2 emulator: SPI responder that returns the 5-byte joystick packet
// and decodes the master's command bytes, including set-LED (0x84).
module jstk2_spi_responder (
  input  logic                       clk,
  input  logic                       rst,
  jstk2_spi_responder_if.slave       spi,
  input  logic [9:0]                 x_val,
  input  logic [9:0]                 y_val,
  input  logic [1:0]                 btn,
  output logic [7:0]                 cmd_byte,
  output logic [7:0]                 led_r,
  output logic [7:0]                 led_g,
  output logic [7:0]                 led_b,
  output logic                       led_valid,
  output logic                       frame_done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic        sclk_p0, sclk_p1, sclk_p2;
  logic        ss_p0, ss_p1, ss_p2;
  logic        mosi_p0, mosi_p1;
  logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic        start_frame, end_frame, shift_in, shift_out;
  logic [39:0] tx;
  logic [7:0]  rx, rx_byte, sh_r, sh_g;
  logic [2:0]  bit_cnt, byte_cnt;
  logic        miso_q;

  // p0/p1: two-flop synchronisers; p2: history stage for edge detection.
  // These track the pins continuously so a reset never fabricates an edge.
  always_ff @(posedge clk) begin
    sclk_p0 <= spi.SCLK;
    sclk_p1 <= sclk_p0;
    sclk_p2 <= sclk_p1;
    ss_p0   <= spi.SS;
    ss_p1   <= ss_p0;
    ss_p2   <= ss_p1;
    mosi_p0 <= spi.MOSI;
    mosi_p1 <= mosi_p0;
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign ss_rise   = ss_p1 & ~ss_p2;
  assign ss_fall   = ~ss_p1 & ss_p2;
  assign rx_byte   = {rx[6:0], mosi_p1};

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle action strobes; SS deassertion masks any SCLK edge.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          start_frame = 1'b1;
          state_nxt   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          end_frame = 1'b1;
          state_nxt = IDLE;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet and receive shift registers plus LED shadow bytes.
  always_ff @(posedge clk) begin
    if (start_frame)
      tx <= {x_val[7:0], 6'b0, x_val[9:8], y_val[7:0], 6'b0, y_val[9:8], 6'b0, btn};
    else if (shift_out)
      tx <= {tx[38:0], 1'b0};
    if (shift_in) begin
      rx <= rx_byte;
      if (bit_cnt == 3'd7) begin
        case (byte_cnt)
          3'd1:    sh_r <= rx_byte;
          3'd2:    sh_g <= rx_byte;
          default: ;
        endcase
      end
    end
  end

  // MISO, bit/byte counters, command decode and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_q     <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 3'd0;
      cmd_byte   <= 8'h00;
      led_r      <= 8'h00;
      led_g      <= 8'h00;
      led_b      <= 8'h00;
      led_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      led_valid  <= 1'b0;
      frame_done <= end_frame;
      if (start_frame) begin
        miso_q   <= x_val[7];
        bit_cnt  <= 3'd0;
        byte_cnt <= 3'd0;
      end else if (end_frame) begin
        miso_q <= 1'b0;
      end else begin
        if (shift_out) miso_q <= tx[38];
        if (shift_in) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt != 3'd5) byte_cnt <= byte_cnt + 3'd1;
            case (byte_cnt)
              3'd0: cmd_byte <= rx_byte;
              3'd3: begin
                if (cmd_byte == 8'h84) begin
                  led_r     <= sh_r;
                  led_g     <= sh_g;
                  led_b     <= rx_byte;
                  led_valid <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign spi.MISO = miso_q;

endmodule
